// File: rtl/ysyx_22041461_if.sv
// Instruction fetch stage: one outstanding request, registered hand-off to ID,
// redirect from ID with kill of any in-flight response.
module ysyx_22041461_if #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [63:0] inst_addr,
    input  logic        inst_ready,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    input  logic        IF_ctrl,
    input  logic [63:0] next_pc,
    input  logic        ID_ready,
    output logic        IF_valid_out,
    output logic [31:0] inst,
    output logic [63:0] pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            inst_q     <= 32'h0000_0013;
            pc_q       <= 64'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        unique case (state_q)
            S_FETCH: begin
                if (IF_ctrl) begin
                    fetch_pc_d = next_pc;
                    // A request accepted alongside a redirect is stale on arrival
                    if (inst_ready) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (inst_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (IF_ctrl) begin
                    fetch_pc_d = next_pc;
                    if (inst_rvalid) begin
                        state_d = S_FETCH;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (inst_rvalid) begin
                    if (kill_q) begin
                        state_d = S_FETCH;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        inst_d  = inst_rdata;
                        pc_d    = fetch_pc_q;
                        valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (IF_ctrl) begin
                    fetch_pc_d = next_pc;
                    state_d    = S_FETCH;
                    valid_d    = 1'b0;
                end else if (ID_ready) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = S_FETCH;
                    valid_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    assign inst_req     = (state_q == S_FETCH);
    assign inst_addr    = fetch_pc_q;
    assign IF_valid_out = valid_q;
    assign inst         = inst_q;
    assign pc           = pc_q;

endmodule

// File: doc/ysyx_22041461_if.md
YSYX_22041461_IF -- requirements
Module: ysyx_22041461_IF

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port inst_req, output, 1: fetch request to instruction memory.
REQ-005 SHALL have port inst_addr, output, 64: fetch address; equals the internal PC whenever inst_req=1.
REQ-006 SHALL have port inst_ready, input, 1: memory accepts the request in the cycle where inst_req and inst_ready are both 1.
REQ-007 SHALL have port inst_rvalid, input, 1: one-cycle strobe marking response data.
REQ-008 SHALL have port inst_rdata, input, 32: instruction word, valid only with inst_rvalid.
REQ-009 SHALL have port IF_ctrl, input, 1: redirect strobe from ID.
REQ-010 SHALL have port next_pc, input, 64: redirect target, sampled only when IF_ctrl=1.
REQ-011 SHALL have port ID_ready, input, 1: ID consumes the held instruction this cycle.
REQ-012 SHALL have port IF_valid_out, output, 1: inst and pc hold a live instruction for ID.
REQ-013 SHALL have port inst, output, 32: registered instruction to ID.
REQ-014 SHALL have port pc, output, 64: registered address of inst.

Function
REQ-015 SHALL implement a three-state FSM: FETCH (inst_req=1), WAIT (request accepted, awaiting inst_rvalid), HOLD (IF_valid_out=1, awaiting ID_ready).
REQ-016 FETCH SHALL go to WAIT when inst_ready=1; otherwise it stays in FETCH with inst_addr stable.
REQ-017 WAIT SHALL go to HOLD on inst_rvalid when no kill is pending, registering inst<=inst_rdata and pc<=PC.
REQ-018 HOLD SHALL go to FETCH when ID_ready=1, with PC<=PC+4 (64-bit add, wraps modulo 2^64).
REQ-019 Outputs inst, pc and IF_valid_out SHALL be registered, so a zero-wait memory gives inst_req at cycle N, inst_rvalid at N+1, IF_valid_out at N+2.
REQ-020 IF_ctrl=1 SHALL take priority over every other event, and its target SHALL win over the PC+4 update.
REQ-021 IF_ctrl=1 in FETCH SHALL set PC<=next_pc; if inst_ready is also 1, the accepted request SHALL be marked killed.
REQ-022 IF_ctrl=1 in WAIT SHALL set PC<=next_pc and set a kill flag.
REQ-023 IF_ctrl=1 in HOLD SHALL clear IF_valid_out the next cycle, set PC<=next_pc and go to FETCH.
REQ-024 A killed response SHALL be discarded: WAIT goes to FETCH on its inst_rvalid, kill clears, and IF_valid_out stays 0.
REQ-025 Exactly one request SHALL be outstanding at a time; inst_req SHALL be 0 in WAIT and HOLD.
REQ-026 IF_ctrl together with inst_rvalid in WAIT SHALL discard that response and go to FETCH at next_pc next cycle.
REQ-027 inst and pc SHALL stay stable while IF_valid_out=1 and ID_ready=0.
REQ-028 inst_rvalid outside WAIT SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force: state=FETCH, PC=RESET_PC, IF_valid_out=0, inst=32'h0000_0013 (nop), pc=64'h0, kill=0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the request, and any later stray inst_rvalid SHALL be ignored per REQ-028.
REQ-031 inst_req SHALL assert in the first clock after rst deasserts.

Verification
REQ-032 Reset release, inst_ready=1, rvalid one cycle later with rdata=32'h00000093, ID_ready=1 -> IF_valid_out=1 with pc=0x80000000 two cycles after the request; next inst_addr=0x80000004.
REQ-033 ID_ready=0 for 5 cycles in HOLD -> inst and pc unchanged, inst_req=0 throughout; ID_ready=1 -> FETCH at PC+4.
REQ-034 IF_ctrl=1 with next_pc=0x80000100 in WAIT, then rvalid with rdata=0xdeadbeef -> IF_valid_out stays 0; next inst_addr=0x80000100.
REQ-035 IF_ctrl=1 with next_pc=0x80000040 in HOLD with ID_ready=1 -> next inst_addr=0x80000040, not PC+4.
REQ-036 inst_ready=0 for 3 cycles in FETCH -> inst_req held high with inst_addr constant; one request is counted after acceptance.
REQ-037 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch consumed -> next inst_addr=64'h0.
